// File: rtl/params_list_pkg.sv
// Shared constants and types for the uplink packing scheduler.
//   - Default dimensions of a slot burst (PRBs, REs, symbols, slots, gap).
//   - Fixed index widths shared with package_data.
//   - Scheduler state encoding.
package params_list_pkg;

    localparam int NUM_PRB_DEF  = 132;
    localparam int NUM_RE_DEF   = 12;
    localparam int NUM_SYM_DEF  = 14;
    localparam int NUM_SLOT_DEF = 20;
    localparam int SYM_GAP_DEF  = 4;

    localparam int PRB_W  = 9;
    localparam int SYM_W  = 4;
    localparam int ADDR_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/pusch_pkg_sched.sv
// pusch_pkg_sched: walks symbols, PRBs and REs of one slot per slot strobe
// and emits the per-RE beat stream (with framing and IQ RAM address) that
// package_data packs.
//
// Ports:
//   i_clk, i_reset_n   clock, asynchronous active-low reset
//   i_enable           arms the scheduler (only looked at in IDLE)
//   i_hfp              one-cycle slot-start strobe
//   i_ready            downstream accepts the current beat
//   o_vld/o_sop/o_eop  beat valid, first RE / last RE of a PRB
//   o_re_idx, o_prb_idx, o_sym_idx, o_slot_idx   beat indices
//   o_rd_addr          IQ RAM address (prb*NUM_RE + re)
//   o_busy             scheduler is not idle
//   o_done             pulse after the last beat of a slot is accepted
//   o_overrun          pulse when a slot strobe aborts an unfinished slot
//   o_state            current FSM state (debug)
//
// Handshake: a beat transfers on a cycle where o_vld && i_ready. While o_vld
// is high and i_ready is low every beat output holds; o_vld only falls after
// the final beat of a symbol has been accepted (or on abort/reset).
module pusch_pkg_sched
    import params_list_pkg::*;
#(
    parameter int NUM_PRB  = NUM_PRB_DEF,
    parameter int NUM_RE   = NUM_RE_DEF,
    parameter int NUM_SYM  = NUM_SYM_DEF,
    parameter int NUM_SLOT = NUM_SLOT_DEF,
    parameter int SYM_GAP  = SYM_GAP_DEF
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_enable,
    input  logic                        i_hfp,
    input  logic                        i_ready,
    output logic                        o_vld,
    output logic                        o_sop,
    output logic                        o_eop,
    output logic [$clog2(NUM_RE)-1:0]   o_re_idx,
    output logic [PRB_W-1:0]            o_prb_idx,
    output logic [SYM_W-1:0]            o_sym_idx,
    output logic [$clog2(NUM_SLOT)-1:0] o_slot_idx,
    output logic [ADDR_W-1:0]           o_rd_addr,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_overrun,
    output logic [1:0]                  o_state
);

    localparam int RE_W   = $clog2(NUM_RE);
    localparam int SLOT_W = $clog2(NUM_SLOT);
    localparam int GAP_W  = (SYM_GAP > 1) ? $clog2(SYM_GAP) : 1;

    localparam logic [RE_W-1:0]   RE_LAST   = RE_W'(NUM_RE - 1);
    localparam logic [PRB_W-1:0]  PRB_LAST  = PRB_W'(NUM_PRB - 1);
    localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(NUM_SYM - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOT - 1);
    // Unreachable all-ones value when SYM_GAP is 0: GAP is never entered then.
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(SYM_GAP - 1);

    sched_state_e        state_q, state_d;
    logic [RE_W-1:0]     re_q, re_d;
    logic [PRB_W-1:0]    prb_q, prb_d;
    logic [SYM_W-1:0]    sym_q, sym_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                slot_seen_q, slot_seen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                vld_q, vld_d;
    logic                sop_q, sop_d;
    logic                eop_q, eop_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;

    logic                start;
    logic [SLOT_W-1:0]   slot_adv;

    // Slot index for the next started slot. Before the first strobe after
    // reset there is no current slot, so the first one is numbered 0.
    always_comb begin
        slot_adv = '0;
        if (slot_seen_q && (slot_q != SLOT_LAST)) begin
            slot_adv = slot_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        re_d        = re_q;
        prb_d       = prb_q;
        sym_d       = sym_q;
        slot_d      = slot_q;
        slot_seen_d = slot_seen_q;
        addr_d      = addr_q;
        gap_d       = gap_q;
        done_d      = 1'b0;
        overrun_d   = 1'b0;
        start       = 1'b0;

        // A strobe while busy wins over any beat advance this cycle.
        if (i_hfp && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
            start     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_hfp && i_enable) begin
                        start = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_ready) begin
                        if (re_q != RE_LAST) begin
                            re_d   = re_q + 1'b1;
                            addr_d = addr_q + 1'b1;
                        end else if (prb_q != PRB_LAST) begin
                            re_d   = '0;
                            prb_d  = prb_q + 1'b1;
                            addr_d = addr_q + 1'b1;
                        end else begin
                            // End of symbol: address restarts with the symbol.
                            re_d   = '0;
                            prb_d  = '0;
                            addr_d = '0;
                            if (sym_q == SYM_LAST) begin
                                sym_d   = '0;
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                sym_d = sym_q + 1'b1;
                                gap_d = '0;
                                if (SYM_GAP > 0) begin
                                    state_d = ST_GAP;
                                end
                            end
                        end
                    end
                end
                ST_GAP: begin
                    // Gap length is fixed; i_ready plays no part here.
                    if (gap_q == GAP_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (start) begin
            state_d     = ST_RUN;
            re_d        = '0;
            prb_d       = '0;
            sym_d       = '0;
            addr_d      = '0;
            gap_d       = '0;
            slot_d      = slot_adv;
            slot_seen_d = 1'b1;
        end

        // Framing outputs are registered from next-state values so they line
        // up with the indices they describe.
        vld_d  = (state_d == ST_RUN);
        sop_d  = vld_d && (re_d == '0);
        eop_d  = vld_d && (re_d == RE_LAST);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            re_q        <= '0;
            prb_q       <= '0;
            sym_q       <= '0;
            slot_q      <= '0;
            slot_seen_q <= 1'b0;
            addr_q      <= '0;
            gap_q       <= '0;
            vld_q       <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            re_q        <= re_d;
            prb_q       <= prb_d;
            sym_q       <= sym_d;
            slot_q      <= slot_d;
            slot_seen_q <= slot_seen_d;
            addr_q      <= addr_d;
            gap_q       <= gap_d;
            vld_q       <= vld_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_vld      = vld_q;
    assign o_sop      = sop_q;
    assign o_eop      = eop_q;
    assign o_re_idx   = re_q;
    assign o_prb_idx  = prb_q;
    assign o_sym_idx  = sym_q;
    assign o_slot_idx = slot_q;
    assign o_rd_addr  = addr_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_overrun  = overrun_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_pusch_pkg_sched.sv
// Directed bench for pusch_pkg_sched with a small geometry:
// 4 PRBs x 12 REs, 2 symbols, 3 gap cycles, 3 slots.
module tb_pusch_pkg_sched;

    localparam int NUM_PRB  = 4;
    localparam int NUM_RE   = 12;
    localparam int NUM_SYM  = 2;
    localparam int NUM_SLOT = 3;
    localparam int SYM_GAP  = 3;
    localparam int BEATS    = NUM_PRB * NUM_RE;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        hfp;
    logic        ready;
    logic        vld, sop, eop, busy, done, overrun;
    logic [3:0]  re_idx;
    logic [8:0]  prb_idx;
    logic [3:0]  sym_idx;
    logic [1:0]  slot_idx;
    logic [10:0] rd_addr;
    logic [1:0]  state;

    int total;
    int bad;

    pusch_pkg_sched #(
        .NUM_PRB  (NUM_PRB),
        .NUM_RE   (NUM_RE),
        .NUM_SYM  (NUM_SYM),
        .NUM_SLOT (NUM_SLOT),
        .SYM_GAP  (SYM_GAP)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_enable   (enable),
        .i_hfp      (hfp),
        .i_ready    (ready),
        .o_vld      (vld),
        .o_sop      (sop),
        .o_eop      (eop),
        .o_re_idx   (re_idx),
        .o_prb_idx  (prb_idx),
        .o_sym_idx  (sym_idx),
        .o_slot_idx (slot_idx),
        .o_rd_addr  (rd_addr),
        .o_busy     (busy),
        .o_done     (done),
        .o_overrun  (overrun),
        .o_state    (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_hfp();
        hfp = 1'b1;
        step();
        hfp = 1'b0;
    endtask

    // Checks nbeats beats of symbol sym starting at the beat currently shown.
    // With stall set, i_ready is held low for 5 cycles while re_idx==5.
    task automatic symbol(input int sym, input int nbeats, input bit stall);
        for (int k = 0; k < nbeats; k++) begin
            chk("vld",     32'(vld),     32'd1);
            chk("sop",     32'(sop),     32'((k % NUM_RE) == 0));
            chk("eop",     32'(eop),     32'((k % NUM_RE) == NUM_RE - 1));
            chk("re_idx",  32'(re_idx),  32'(k % NUM_RE));
            chk("prb_idx", 32'(prb_idx), 32'(k / NUM_RE));
            chk("sym_idx", 32'(sym_idx), 32'(sym));
            chk("rd_addr", 32'(rd_addr), 32'(k));
            chk("busy",    32'(busy),    32'd1);
            chk("done_run", 32'(done),   32'd0);
            chk("ovr_run", 32'(overrun), 32'd0);
            if (stall && k == 5) begin
                ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    chk("stall_vld",  32'(vld),     32'd1);
                    chk("stall_addr", 32'(rd_addr), 32'd5);
                    chk("stall_re",   32'(re_idx),  32'd5);
                    chk("stall_prb",  32'(prb_idx), 32'd0);
                    chk("stall_sop",  32'(sop),     32'd0);
                end
                ready = 1'b1;
            end
            step();
        end
    endtask

    task automatic gap();
        for (int g = 0; g < SYM_GAP; g++) begin
            chk("gap_vld",   32'(vld),   32'd0);
            chk("gap_busy",  32'(busy),  32'd1);
            chk("gap_state", 32'(state), 32'd2);
            step();
        end
    endtask

    task automatic run_slot(input int exp_slot, input bit stall);
        pulse_hfp();
        chk("slot_idx", 32'(slot_idx), 32'(exp_slot));
        symbol(0, BEATS, stall);
        gap();
        symbol(1, BEATS, 1'b0);
        chk("done",       32'(done),     32'd1);
        chk("done_busy",  32'(busy),     32'd0);
        chk("done_vld",   32'(vld),      32'd0);
        chk("done_slot",  32'(slot_idx), 32'(exp_slot));
        chk("done_state", 32'(state),    32'd0);
        step();
        chk("done_clear", 32'(done),     32'd0);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        enable = 1'b0;
        hfp    = 1'b0;
        ready  = 1'b1;
        repeat (3) step();

        // reset state
        chk("rst_vld",  32'(vld),      32'd0);
        chk("rst_sop",  32'(sop),      32'd0);
        chk("rst_busy", 32'(busy),     32'd0);
        chk("rst_done", 32'(done),     32'd0);
        chk("rst_addr", 32'(rd_addr),  32'd0);
        chk("rst_slot", 32'(slot_idx), 32'd0);
        rst_n = 1'b1;
        step();

        // strobe while disabled is ignored
        pulse_hfp();
        chk("dis_vld",  32'(vld),      32'd0);
        chk("dis_busy", 32'(busy),     32'd0);
        step();
        chk("dis_vld2", 32'(vld),      32'd0);
        chk("dis_slot", 32'(slot_idx), 32'd0);

        // four full slots: first with a stall, slot index wraps 0,1,2,0
        enable = 1'b1;
        run_slot(0, 1'b1);
        run_slot(1, 1'b0);
        run_slot(2, 1'b0);
        run_slot(0, 1'b0);

        // overrun at sym1 prb2
        pulse_hfp();
        chk("ovr_slot0", 32'(slot_idx), 32'd1);
        symbol(0, BEATS, 1'b0);
        gap();
        symbol(1, 2 * NUM_RE, 1'b0);
        chk("pre_ovr_prb", 32'(prb_idx), 32'd2);
        chk("pre_ovr_sym", 32'(sym_idx), 32'd1);
        pulse_hfp();
        chk("ovr_pulse", 32'(overrun),  32'd1);
        chk("ovr_vld",   32'(vld),      32'd1);
        chk("ovr_sop",   32'(sop),      32'd1);
        chk("ovr_sym",   32'(sym_idx),  32'd0);
        chk("ovr_prb",   32'(prb_idx),  32'd0);
        chk("ovr_re",    32'(re_idx),   32'd0);
        chk("ovr_addr",  32'(rd_addr),  32'd0);
        chk("ovr_slot",  32'(slot_idx), 32'd2);
        step();
        chk("ovr_clear", 32'(overrun),  32'd0);
        chk("ovr_addr1", 32'(rd_addr),  32'd1);
        repeat (11) step();
        chk("mid_prb",  32'(prb_idx), 32'd1);
        chk("mid_addr", 32'(rd_addr), 32'd12);

        // asynchronous reset mid-symbol
        rst_n = 1'b0;
        #1;
        chk("arst_vld",   32'(vld),      32'd0);
        chk("arst_sop",   32'(sop),      32'd0);
        chk("arst_busy",  32'(busy),     32'd0);
        chk("arst_prb",   32'(prb_idx),  32'd0);
        chk("arst_addr",  32'(rd_addr),  32'd0);
        chk("arst_slot",  32'(slot_idx), 32'd0);
        chk("arst_state", 32'(state),    32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("arst_done", 32'(done), 32'd0);

        // first slot after reset is numbered 0 again
        run_slot(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pusch_pkg_sched.md
# pusch_pkg_sched

Sequencer for the uplink packing path: on each half-frame/slot strobe it walks symbols, PRBs and REs in order and drives the per-RE valid/sop/eop stream, PRB/symbol/slot indices and IQ source-RAM read address consumed by `package_data`. It honours a downstream ready so the CPRI TX FIFO can throttle it. It is the sole source of packet framing for `package_data`, replacing bench-generated counters.

## Interface
- NUM_PRB, 132, PRBs per symbol
- NUM_RE, 12, REs per PRB
- NUM_SYM, 14, symbols per slot burst
- NUM_SLOT, 20, slot index modulus
- SYM_GAP, 4, idle cycles between symbols (0 allowed)
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_enable  in  1  arms the scheduler; sampled only in IDLE
- i_hfp  in  1  one-cycle slot-start strobe
- i_ready  in  1  downstream can accept the current beat
- o_vld  out  1  beat valid
- o_sop  out  1  first RE of a PRB (re_idx==0)
- o_eop  out  1  last RE of a PRB (re_idx==NUM_RE-1)
- o_re_idx  out  $clog2(NUM_RE)  RE within PRB
- o_prb_idx  out  9  PRB index
- o_sym_idx  out  4  symbol index
- o_slot_idx  out  $clog2(NUM_SLOT)  slot index
- o_rd_addr  out  11  IQ RAM address = prb_idx*NUM_RE + re_idx
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse after last beat of slot accepted
- o_overrun  out  1  one-cycle pulse when i_hfp arrives while busy

## Operation
- States: IDLE, RUN, GAP.
- IDLE: o_vld=0. i_hfp && i_enable → RUN, re/prb/sym = 0, slot_idx advances (first hfp after reset gives slot 0). i_hfp with i_enable=0 ignored, slot unchanged.
- RUN: o_vld=1. Beat accepted when o_vld && i_ready; only then counters advance. re wraps at NUM_RE-1 → prb+1; prb wraps at NUM_PRB-1 → end of symbol.
- End of symbol, not last symbol: sym+1, re/prb=0; → GAP if SYM_GAP>0, else stay RUN (back-to-back, no bubble).
- GAP: o_vld=0, counts SYM_GAP cycles independent of i_ready, then → RUN.
- End of last symbol (sym==NUM_SYM-1): → IDLE, o_done pulse same cycle as transition.
- Stall: i_ready=0 in RUN holds all outputs stable (AXI-style; o_vld never drops without acceptance).
- i_hfp while busy (RUN or GAP): abort current slot, o_overrun pulse, restart at sym/prb/re 0, slot_idx advances; takes priority over beat advance in the same cycle. Ignores i_enable.
- Slot index: wraps NUM_SLOT-1 → 0.
- o_sop/o_eop/o_rd_addr derived from registered re/prb; o_rd_addr computed incrementally (+1 per accepted beat, 0 at symbol start), no multiplier.

## Timing
- All outputs registered. Reset values: o_vld, o_sop, o_eop, o_busy, o_done, o_overrun = 0; all indices and o_rd_addr = 0; state IDLE; slot counter in "no slot yet" state so first hfp yields 0.
- i_hfp at cycle T (IDLE, enabled) → o_vld=1, o_sop=1, indices 0 at T+1.
- With i_ready=1 throughout: one PRB = NUM_RE cycles; one symbol = NUM_PRB*NUM_RE cycles; slot = NUM_SYM*NUM_PRB*NUM_RE + (NUM_SYM-1)*SYM_GAP cycles from first beat to o_done.
- Last-beat acceptance of a non-final symbol at T → first beat of next symbol at T+1+SYM_GAP.
- Reset assertion mid-run: outputs go to reset values immediately (asynchronous); no o_done.

## Structure
- Shared package `params_list_pkg`: NUM_PRB/NUM_RE/NUM_SYM/NUM_SLOT defaults, state enum typedef, index width constants.
- Single module; no sub-module needed (one nested counter chain plus a 3-state FSM).

## Test plan
- Nominal: NUM_PRB=4, NUM_SYM=2, SYM_GAP=3, ready=1, hfp → 48 beats sym0, 3 idle cycles, 48 beats sym1, o_done; o_rd_addr 0..47 per symbol, sop every 12 beats.
- Stall: drop i_ready for 5 cycles at re_idx=5 → outputs frozen, beat count still 48 per symbol, no skipped/duplicated addr.
- Overrun: second hfp at sym1 prb2 → o_overrun pulse, restart at sym0 prb0 re0, slot_idx +1.
- Disabled: i_enable=0, hfp → no beats, slot_idx unchanged; enable then hfp → slot 0.
- Slot wrap: NUM_SLOT=3, four complete slots → o_slot_idx 0,1,2,0.
- Reset mid-symbol: i_reset_n low at prb1 → all outputs 0 immediately, IDLE; next hfp starts slot 0.
